// File: rtl/dac_playback.sv
// dac_playback: host-loaded waveform buffer streamed to a parallel DAC,
// one sample per clock, one-shot or looping.
//
// Pipeline: read pointer -> buffer read register -> registered DAC outputs.
// A start accepted on edge E0 issues the read of address 0 on E1 (PRIME)
// and presents it on E2, so address k is read on E1+k and shown on E2+k.
module dac_playback #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  dac_clock,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [ADDR_WIDTH-1:0] play_length,
    input  logic                  loop_enable,
    input  logic                  start_playback,
    input  logic                  stop_playback,
    output logic [DATA_WIDTH-1:0] dac_data,
    output logic                  dac_valid,
    output logic [ADDR_WIDTH-1:0] play_addr,
    output logic                  playback_busy,
    output logic                  playback_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;        // latched play_length
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;  // address read on the next edge
    logic                  tail_q, tail_d;      // last read issued, draining
    logic                  rd_valid_q, rd_valid_d;  // read register holds a sample

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;

    logic [DATA_WIDTH-1:0] dac_data_q, dac_data_d;
    logic                  dac_valid_q, dac_valid_d;
    logic [ADDR_WIDTH-1:0] play_addr_q, play_addr_d;
    logic                  done_q, done_d;

    logic                  drained;

    // The drain is complete once the last sample has left the read register.
    assign drained = tail_q && !rd_valid_q;

    // Buffer write port plus synchronous read of the current read pointer.
    // NOTE: the buffer and its read register carry no reset so they map onto
    // block RAM and keep their contents across reset; the non-blocking
    // assignments make a same-edge read of a written address return the old value.
    always_ff @(posedge dac_clock) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
        rd_data_q <= mem[rd_ptr_q];
        rd_addr_q <= rd_ptr_q;
    end

    // State and control/output registers with asynchronous reset.
    always_ff @(posedge dac_clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= ADDR_ZERO;
            rd_ptr_q    <= ADDR_ZERO;
            tail_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            dac_data_q  <= MIDSCALE;
            dac_valid_q <= 1'b0;
            play_addr_q <= ADDR_ZERO;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            rd_ptr_q    <= rd_ptr_d;
            tail_q      <= tail_d;
            rd_valid_q  <= rd_valid_d;
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
            play_addr_q <= play_addr_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic; stop wins over start everywhere.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_playback && !stop_playback) state_d = PRIME;
            PRIME:   state_d = stop_playback ? IDLE : PLAY;
            PLAY:    if (stop_playback || drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read-pointer sequencing: advance, wrap on loop, or mark the tail.
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        len_d      = len_q;
        rd_ptr_d   = rd_ptr_q;
        tail_d     = tail_q;
        rd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                rd_ptr_d = ADDR_ZERO;
                tail_d   = 1'b0;
                if (start_playback && !stop_playback) begin
                    len_d = play_length;
                end
            end
            PRIME, PLAY: begin
                if (stop_playback || drained) begin
                    rd_ptr_d = ADDR_ZERO;
                    tail_d   = 1'b0;
                end else if (!tail_q) begin
                    rd_valid_d = 1'b1;
                    if (rd_ptr_q == len_q) begin
                        if (loop_enable) begin
                            rd_ptr_d = ADDR_ZERO;
                        end else begin
                            tail_d = 1'b1;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + ADDR_ONE;
                    end
                end
            end
            default: begin
                rd_ptr_d = ADDR_ZERO;
                tail_d   = 1'b0;
            end
        endcase
    end

    // Output logic: forward the read register while busy, else idle values.
    always_comb begin
        dac_data_d  = MIDSCALE;
        dac_valid_d = 1'b0;
        play_addr_d = ADDR_ZERO;
        done_d      = (state_q == PLAY) && !stop_playback && drained;
        if ((state_d != IDLE) && rd_valid_q) begin
            dac_data_d  = rd_data_q;
            dac_valid_d = 1'b1;
            play_addr_d = rd_addr_q;
        end
    end

    assign dac_data      = dac_data_q;
    assign dac_valid     = dac_valid_q;
    assign play_addr     = play_addr_q;
    assign playback_busy = (state_q != IDLE);
    assign playback_done = done_q;

endmodule

// File: tb/tb_dac_playback.sv
// Directed testbench for dac_playback: inputs driven and outputs checked on
// the falling edge, away from the active rising edge.
module tb_dac_playback;

    localparam int DW = 12;
    localparam int AW = 12;
    localparam logic [DW-1:0] MID = 12'd2048;

    logic          dac_clock = 1'b0;
    logic          reset;
    logic          write_en;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;
    logic [AW-1:0] play_length;
    logic          loop_enable;
    logic          start_playback;
    logic          stop_playback;
    logic [DW-1:0] dac_data;
    logic          dac_valid;
    logic [AW-1:0] play_addr;
    logic          playback_busy;
    logic          playback_done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] seq [8];

    dac_playback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .dac_clock      (dac_clock),
        .reset          (reset),
        .write_en       (write_en),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .play_length    (play_length),
        .loop_enable    (loop_enable),
        .start_playback (start_playback),
        .stop_playback  (stop_playback),
        .dac_data       (dac_data),
        .dac_valid      (dac_valid),
        .play_addr      (play_addr),
        .playback_busy  (playback_busy),
        .playback_done  (playback_done)
    );

    always #5 dac_clock = ~dac_clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge dac_clock);
    endtask

    task automatic check_sample(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] val);
        check({tag, ".data"},  32'(dac_data), 32'(val));
        check({tag, ".addr"},  32'(play_addr), 32'(addr));
        check({tag, ".valid"}, 32'(dac_valid), 32'd1);
        check({tag, ".busy"},  32'(playback_busy), 32'd1);
        check({tag, ".done"},  32'(playback_done), 32'd0);
    endtask

    task automatic check_idle(input string tag, input logic done_exp);
        check({tag, ".data"},  32'(dac_data), 32'(MID));
        check({tag, ".addr"},  32'(play_addr), 32'd0);
        check({tag, ".valid"}, 32'(dac_valid), 32'd0);
        check({tag, ".busy"},  32'(playback_busy), 32'd0);
        check({tag, ".done"},  32'(playback_done), 32'(done_exp));
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_en   = 1'b1;
        write_addr = a;
        write_data = d;
        tick();
        write_en   = 1'b0;
    endtask

    // Returns just after the start edge E0.
    task automatic start_play(input logic [AW-1:0] len, input logic lp);
        play_length    = len;
        loop_enable    = lp;
        start_playback = 1'b1;
        tick();
        start_playback = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b1;
        write_en = 1'b0;
        write_addr = '0;
        write_data = '0;
        play_length = '0;
        loop_enable = 1'b0;
        start_playback = 1'b0;
        stop_playback = 1'b0;

        // Reset values
        #12;
        check_idle("reset", 1'b0);
        tick();
        reset = 1'b0;

        // One-shot ramp 0..7
        for (int i = 0; i < 8; i++) write_word(12'(i), 12'(i));
        start_play(12'd7, 1'b0);
        check("ramp.e0.busy", 32'(playback_busy), 32'd1);
        check("ramp.e0.valid", 32'(dac_valid), 32'd0);
        tick();
        check("ramp.e1.valid", 32'(dac_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_sample($sformatf("ramp.s%0d", k), 12'(k), 12'(k));
        end
        tick();
        check_idle("ramp.end", 1'b1);
        tick();
        check_idle("ramp.after", 1'b0);

        // Looping playback of four samples, then loop released mid-pass
        seq[0] = 12'd100; seq[1] = 12'd200; seq[2] = 12'd300; seq[3] = 12'd400;
        seq[4] = 12'd4;   seq[5] = 12'd5;   seq[6] = 12'd6;   seq[7] = 12'd7;
        for (int i = 0; i < 4; i++) write_word(12'(i), seq[i]);
        start_play(12'd3, 1'b1);
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            check_sample($sformatf("loop.s%0d", k), 12'(k % 4), seq[k % 4]);
        end
        loop_enable = 1'b0;
        tick();
        check_sample("loop.tail2", 12'd2, 12'd300);
        tick();
        check_sample("loop.tail3", 12'd3, 12'd400);
        tick();
        check_idle("loop.end", 1'b1);

        // Stop while sample 5 of 8 is on the output
        start_play(12'd7, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            check_sample($sformatf("stop.s%0d", k), 12'(k), seq[k]);
        end
        stop_playback = 1'b1;
        tick();
        check_idle("stop.now", 1'b0);
        stop_playback = 1'b0;
        tick();
        check_idle("stop.next", 1'b0);
        tick();
        check_idle("stop.next2", 1'b0);

        // Stop and start together in IDLE: nothing starts
        stop_playback  = 1'b1;
        start_playback = 1'b1;
        tick();
        check_idle("both.e0", 1'b0);
        tick();
        check_idle("both.e1", 1'b0);
        stop_playback  = 1'b0;
        start_playback = 1'b0;
        tick();
        check_idle("both.e2", 1'b0);

        // Start while busy is ignored
        start_play(12'd3, 1'b0);
        tick();
        tick();
        check_sample("rebusy.s0", 12'd0, seq[0]);
        tick();
        check_sample("rebusy.s1", 12'd1, seq[1]);
        start_playback = 1'b1;
        tick();
        check_sample("rebusy.s2", 12'd2, seq[2]);
        start_playback = 1'b0;
        tick();
        check_sample("rebusy.s3", 12'd3, seq[3]);
        tick();
        check_idle("rebusy.end", 1'b1);
        tick();
        check_idle("rebusy.after", 1'b0);

        // play_length = 0 one-shot
        start_play(12'd0, 1'b0);
        check("len0.e0.busy", 32'(playback_busy), 32'd1);
        tick();
        check("len0.e1.valid", 32'(dac_valid), 32'd0);
        tick();
        check_sample("len0.s0", 12'd0, seq[0]);
        tick();
        check_idle("len0.end", 1'b1);

        // Write mem[6] while address 2 is on the output
        start_play(12'd7, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check_sample($sformatf("wr6.s%0d", k), 12'(k), seq[k]);
        end
        write_en = 1'b1; write_addr = 12'd6; write_data = 12'hABC;
        tick();
        write_en = 1'b0;
        check_sample("wr6.s3", 12'd3, seq[3]);
        seq[6] = 12'hABC;
        for (int k = 4; k < 8; k++) begin
            tick();
            check_sample($sformatf("wr6.s%0d", k), 12'(k), seq[k]);
        end
        tick();
        check_idle("wr6.end", 1'b1);

        // Write address 4 on the edge it is read: old value goes out
        start_play(12'd7, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            tick();
            check_sample($sformatf("rf.s%0d", k), 12'(k), seq[k]);
        end
        write_en = 1'b1; write_addr = 12'd4; write_data = 12'h555;
        tick();
        write_en = 1'b0;
        check_sample("rf.s3", 12'd3, seq[3]);
        tick();
        check_sample("rf.s4_old", 12'd4, 12'd4);
        tick();
        check_sample("rf.s5", 12'd5, 12'd5);
        tick();
        check_sample("rf.s6", 12'd6, 12'hABC);

        // Asynchronous reset mid-play: outputs idle without a clock edge
        #2;
        reset = 1'b1;
        #1;
        check_idle("areset", 1'b0);
        tick();
        reset = 1'b0;
        tick();
        check_idle("areset.after", 1'b0);

        // Replay after reset: buffer contents intact, including the new mem[4]
        seq[4] = 12'h555;
        start_play(12'd7, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            check_sample($sformatf("replay.s%0d", k), 12'(k), seq[k]);
        end
        tick();
        check_idle("replay.end", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
